// File: rtl/alu_staged_pkg.sv
// Shared types and helpers for the staged ALU: FSM states, command encodings
// per mode, flag bundle and operand-requirement decoding.
package alu_staged_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_WAIT_CYCLES = 16;
  localparam int DEF_MUL_LAT     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_OP,
    ST_EXEC,
    ST_MUL
  } state_t;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10
  } arith_cmd_t;

  typedef enum logic [3:0] {
    L_AND     = 4'd0,
    L_NAND    = 4'd1,
    L_OR      = 4'd2,
    L_NOR     = 4'd3,
    L_XOR     = 4'd4,
    L_XNOR    = 4'd5,
    L_NOT_A   = 4'd6,
    L_NOT_B   = 4'd7,
    L_SHR1_A  = 4'd8,
    L_SHL1_A  = 4'd9,
    L_SHR1_B  = 4'd10,
    L_SHL1_B  = 4'd11,
    L_ROL_A_B = 4'd12,
    L_ROR_A_B = 4'd13
  } logic_cmd_t;

  typedef struct packed {
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
    logic err;
  } alu_flags_t;

  // Operands a command needs as an inp_valid mask; 2'b00 marks an illegal
  // command, which completes as soon as any operand is presented.
  function automatic logic [1:0] operand_need(input logic mode, input logic [3:0] cmd);
    logic [1:0] need;
    need = 2'b00;
    if (mode) begin
      case (cmd)
        A_INC_A, A_DEC_A: need = 2'b01;
        A_INC_B, A_DEC_B: need = 2'b10;
        A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP, A_MUL_INC, A_MUL_SHL: need = 2'b11;
        default: need = 2'b00;
      endcase
    end else begin
      case (cmd)
        L_NOT_A, L_SHR1_A, L_SHL1_A: need = 2'b01;
        L_NOT_B, L_SHR1_B, L_SHL1_B: need = 2'b10;
        L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_ROL_A_B, L_ROR_A_B: need = 2'b11;
        default: need = 2'b00;
      endcase
    end
    return need;
  endfunction

  function automatic logic is_mul_op(input logic mode, input logic [3:0] cmd);
    return mode && (cmd == A_MUL_INC || cmd == A_MUL_SHL);
  endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// Multiply pipeline: product formed on the start edge, then carried through
// MUL_LAT-1 register stages so the core's result register lands at MUL_LAT.
module alu_mul_pipe #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               start,
  input  logic [WIDTH:0]     a,
  input  logic [WIDTH:0]     b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] product
);

  localparam int STAGES = MUL_LAT - 1;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod_comb;
  logic [2*WIDTH-1:0] prod_reg [STAGES];
  logic               vld_reg  [STAGES];

  // Multiplying in the 2*WIDTH context keeps the product modulo 2^(2*WIDTH).
  assign a_ext     = {{(WIDTH-1){1'b0}}, a};
  assign b_ext     = {{(WIDTH-1){1'b0}}, b};
  assign prod_comb = a_ext * b_ext;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            prod_reg[gi] <= '0;
            vld_reg[gi]  <= 1'b0;
          end else if (ce) begin
            prod_reg[gi] <= prod_comb;
            vld_reg[gi]  <= start;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            prod_reg[gi] <= '0;
            vld_reg[gi]  <= 1'b0;
          end else if (ce) begin
            prod_reg[gi] <= prod_reg[gi-1];
            vld_reg[gi]  <= vld_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid = vld_reg[STAGES-1];
  assign product   = prod_reg[STAGES-1];

endmodule

// File: rtl/alu_staged_core.sv
// Staged ALU: collects operands (possibly over several cycles), executes
// single-cycle ops directly and routes multiplies through alu_mul_pipe.
module alu_staged_core
  import alu_staged_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int MUL_LAT     = DEF_MUL_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic [3:0]         cmd,
  input  logic [1:0]         inp_valid,
  input  logic               mode,
  input  logic               cin,
  output logic [2*WIDTH-1:0] res,
  output logic               oflow,
  output logic               cout,
  output logic               g,
  output logic               l,
  output logic               e,
  output logic               err,
  output logic               res_valid,
  output logic               busy
);

  localparam int AMT_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH+1)'(1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [3:0]         cmd_q_reg, cmd_q_next;
  logic               mode_q_reg, mode_q_next;
  logic               cin_q_reg, cin_q_next;
  logic [WIDTH-1:0]   opa_q_reg, opa_q_next;
  logic [WIDTH-1:0]   opb_q_reg, opb_q_next;
  logic               have_a_reg, have_a_next;
  logic [2*WIDTH-1:0] res_reg, res_next;
  alu_flags_t         flags_reg, flags_next;
  logic               res_valid_reg, res_valid_next;

  logic               use_q;
  logic [3:0]         cur_cmd;
  logic               cur_mode;
  logic               cur_cin;
  logic [WIDTH-1:0]   cur_a;
  logic [WIDTH-1:0]   cur_b;
  logic [WIDTH:0]     ext_a, ext_b, ext_cin, tmp;
  logic [WIDTH-1:0]   alu_lo;
  alu_flags_t         alu_flags;
  int                 rot_n;
  logic [1:0]         need;
  logic               complete;
  logic               mul_start;
  logic [WIDTH:0]     mul_a, mul_b;
  logic               mul_out_valid;
  logic [2*WIDTH-1:0] mul_prod;

  // While waiting, the captured command and operand win; only the missing
  // operand is taken from the live inputs.
  assign use_q    = (state_reg == ST_WAIT_OP);
  assign cur_cmd  = use_q ? cmd_q_reg  : cmd;
  assign cur_mode = use_q ? mode_q_reg : mode;
  assign cur_cin  = use_q ? cin_q_reg  : cin;
  assign cur_a    = (use_q && have_a_reg)  ? opa_q_reg : opa;
  assign cur_b    = (use_q && !have_a_reg) ? opb_q_reg : opb;
  assign ext_a    = {1'b0, cur_a};
  assign ext_b    = {1'b0, cur_b};
  assign ext_cin  = {{WIDTH{1'b0}}, cur_cin};

  always_comb begin
    alu_lo    = '0;
    alu_flags = '0;
    tmp       = '0;
    rot_n     = 0;
    if (cur_mode) begin
      case (cur_cmd)
        A_ADD:     begin tmp = ext_a + ext_b;           alu_lo = tmp[WIDTH-1:0]; alu_flags.cout  = tmp[WIDTH]; end
        A_SUB:     begin tmp = ext_a - ext_b;           alu_lo = tmp[WIDTH-1:0]; alu_flags.oflow = tmp[WIDTH]; end
        A_ADD_CIN: begin tmp = ext_a + ext_b + ext_cin; alu_lo = tmp[WIDTH-1:0]; alu_flags.cout  = tmp[WIDTH]; end
        A_SUB_CIN: begin tmp = ext_a - ext_b - ext_cin; alu_lo = tmp[WIDTH-1:0]; alu_flags.oflow = tmp[WIDTH]; end
        A_INC_A:   begin tmp = ext_a + ONE_EXT;         alu_lo = tmp[WIDTH-1:0]; alu_flags.cout  = tmp[WIDTH]; end
        A_DEC_A:   begin tmp = ext_a - ONE_EXT;         alu_lo = tmp[WIDTH-1:0]; alu_flags.oflow = tmp[WIDTH]; end
        A_INC_B:   begin tmp = ext_b + ONE_EXT;         alu_lo = tmp[WIDTH-1:0]; alu_flags.cout  = tmp[WIDTH]; end
        A_DEC_B:   begin tmp = ext_b - ONE_EXT;         alu_lo = tmp[WIDTH-1:0]; alu_flags.oflow = tmp[WIDTH]; end
        A_CMP: begin
          alu_flags.g = (cur_a > cur_b);
          alu_flags.l = (cur_a < cur_b);
          alu_flags.e = (cur_a == cur_b);
        end
        A_MUL_INC, A_MUL_SHL: ;
        default: alu_flags.err = 1'b1;
      endcase
    end else begin
      case (cur_cmd)
        L_AND:    alu_lo = cur_a & cur_b;
        L_NAND:   alu_lo = ~(cur_a & cur_b);
        L_OR:     alu_lo = cur_a | cur_b;
        L_NOR:    alu_lo = ~(cur_a | cur_b);
        L_XOR:    alu_lo = cur_a ^ cur_b;
        L_XNOR:   alu_lo = ~(cur_a ^ cur_b);
        L_NOT_A:  alu_lo = ~cur_a;
        L_NOT_B:  alu_lo = ~cur_b;
        L_SHR1_A: alu_lo = cur_a >> 1;
        L_SHL1_A: alu_lo = cur_a << 1;
        L_SHR1_B: alu_lo = cur_b >> 1;
        L_SHL1_B: alu_lo = cur_b << 1;
        L_ROL_A_B, L_ROR_A_B: begin
          if (|(cur_b >> AMT_W)) begin
            alu_flags.err = 1'b1;
          end else begin
            rot_n = int'(cur_b[AMT_W-1:0]) % WIDTH;
            if (cur_cmd == L_ROL_A_B)
              alu_lo = (cur_a << rot_n) | (cur_a >> (WIDTH - rot_n));
            else
              alu_lo = (cur_a >> rot_n) | (cur_a << (WIDTH - rot_n));
          end
        end
        default: alu_flags.err = 1'b1;
      endcase
    end
  end

  always_comb begin
    if (cur_cmd == A_MUL_INC) begin
      mul_a = ext_a + ONE_EXT;
      mul_b = ext_b + ONE_EXT;
    end else begin
      mul_a = {1'b0, cur_a[WIDTH-2:0], 1'b0};
      mul_b = ext_b;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cmd_q_next     = cmd_q_reg;
    mode_q_next    = mode_q_reg;
    cin_q_next     = cin_q_reg;
    opa_q_next     = opa_q_reg;
    opb_q_next     = opb_q_reg;
    have_a_next    = have_a_reg;
    res_next       = res_reg;
    flags_next     = flags_reg;
    res_valid_next = 1'b0;
    mul_start      = 1'b0;
    complete       = 1'b0;
    need           = operand_need(cur_mode, cur_cmd);

    case (state_reg)
      ST_IDLE: begin
        if (inp_valid != 2'b00) begin
          if (need == 2'b00 || (inp_valid & need) == need) begin
            complete = 1'b1;
          end else if (need == 2'b11) begin
            cmd_q_next  = cmd;
            mode_q_next = mode;
            cin_q_next  = cin;
            opa_q_next  = opa;
            opb_q_next  = opb;
            have_a_next = inp_valid[0];
            cnt_next    = '0;
            state_next  = ST_WAIT_OP;
          end
        end
      end
      ST_WAIT_OP: begin
        if (have_a_reg ? inp_valid[1] : inp_valid[0]) begin
          complete = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          res_next       = '0;
          flags_next     = '0;
          flags_next.err = 1'b1;
          res_valid_next = 1'b1;
          state_next     = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_EXEC: state_next = ST_IDLE;
      ST_MUL: begin
        if (mul_out_valid) begin
          res_next       = mul_prod;
          flags_next     = '0;
          res_valid_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (complete) begin
      if (is_mul_op(cur_mode, cur_cmd)) begin
        mul_start  = 1'b1;
        state_next = ST_MUL;
      end else begin
        res_next       = {{WIDTH{1'b0}}, alu_lo};
        flags_next     = alu_flags;
        res_valid_next = 1'b1;
        state_next     = ST_EXEC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      cmd_q_reg     <= '0;
      mode_q_reg    <= 1'b0;
      cin_q_reg     <= 1'b0;
      opa_q_reg     <= '0;
      opb_q_reg     <= '0;
      have_a_reg    <= 1'b0;
      res_reg       <= '0;
      flags_reg     <= '0;
      res_valid_reg <= 1'b0;
    end else if (ce) begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cmd_q_reg     <= cmd_q_next;
      mode_q_reg    <= mode_q_next;
      cin_q_reg     <= cin_q_next;
      opa_q_reg     <= opa_q_next;
      opb_q_reg     <= opb_q_next;
      have_a_reg    <= have_a_next;
      res_reg       <= res_next;
      flags_reg     <= flags_next;
      res_valid_reg <= res_valid_next;
    end
  end

  alu_mul_pipe #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT)
  ) u_mul_pipe (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .start     (mul_start),
    .a         (mul_a),
    .b         (mul_b),
    .out_valid (mul_out_valid),
    .product   (mul_prod)
  );

  // A pending pulse is masked while ce is low and shows once ce returns.
  assign res_valid = res_valid_reg & ce;
  assign busy      = (state_reg == ST_WAIT_OP) || (state_reg == ST_MUL);
  assign res       = res_reg;
  assign oflow     = flags_reg.oflow;
  assign cout      = flags_reg.cout;
  assign g         = flags_reg.g;
  assign l         = flags_reg.l;
  assign e         = flags_reg.e;
  assign err       = flags_reg.err;

endmodule

// File: tb/tb_alu_staged_core.sv
// Randomized bench for alu_staged_core against an arithmetic reference model.
module tb_alu_staged_core;

  localparam int W     = 8;
  localparam int WAITC = 16;
  localparam int MLAT  = 3;
  localparam int RW    = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b1;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic [3:0]    cmd = '0;
  logic [1:0]    inp_valid = '0;
  logic          mode = 1'b0;
  logic          cin = 1'b0;
  logic [RW-1:0] res;
  logic          oflow, cout, g, l, e, err, res_valid, busy;

  int test_cnt = 0;
  int fail_cnt = 0;

  typedef struct {
    logic [RW-1:0] res;
    bit            cout, oflow, g, l, e, err;
    int            lat;
  } exp_t;

  alu_staged_core #(.WIDTH(W), .WAIT_CYCLES(WAITC), .MUL_LAT(MLAT)) dut (
    .clk(clk), .reset(reset), .ce(ce), .opa(opa), .opb(opb), .cmd(cmd),
    .inp_valid(inp_valid), .mode(mode), .cin(cin), .res(res), .oflow(oflow),
    .cout(cout), .g(g), .l(l), .e(e), .err(err), .res_valid(res_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit two_op(bit m, int c);
    if (m) return c inside {0, 1, 2, 3, 8, 9, 10};
    return c inside {[0:5], 12, 13};
  endfunction

  function automatic exp_t model(bit m, int c, longint a, longint b, bit ci);
    exp_t   r;
    longint mk = (longint'(1) << W) - 1;
    longint m2 = (longint'(1) << RW) - 1;
    longint v  = 0;
    r.res = '0; r.cout = 0; r.oflow = 0; r.g = 0; r.l = 0; r.e = 0; r.err = 0;
    r.lat = 1;
    if (m) begin
      case (c)
        0: begin v = a + b;      r.cout = (v > mk); end
        1: begin v = a - b;      r.oflow = (a < b); end
        2: begin v = a + b + ci; r.cout = (v > mk); end
        3: begin v = a - b - ci; r.oflow = (a < b + ci); end
        4: begin v = a + 1;      r.cout = (v > mk); end
        5: begin v = a - 1;      r.oflow = (a == 0); end
        6: begin v = b + 1;      r.cout = (v > mk); end
        7: begin v = b - 1;      r.oflow = (b == 0); end
        8: begin r.g = (a > b); r.l = (a < b); r.e = (a == b); end
        9:  begin r.res = RW'(((a + 1) * (b + 1)) & m2); r.lat = MLAT; end
        10: begin r.res = RW'((((a * 2) & mk) * b) & m2); r.lat = MLAT; end
        default: r.err = 1;
      endcase
      if (c <= 7) r.res = RW'(v & mk);
    end else begin
      case (c)
        0:  v = a & b;
        1:  v = ~(a & b);
        2:  v = a | b;
        3:  v = ~(a | b);
        4:  v = a ^ b;
        5:  v = ~(a ^ b);
        6:  v = ~a;
        7:  v = ~b;
        8:  v = a >> 1;
        9:  v = a << 1;
        10: v = b >> 1;
        11: v = b << 1;
        12: if (b >= W) r.err = 1; else v = (a << b) | (a >> (W - b));
        13: if (b >= W) r.err = 1; else v = (a >> b) | (a << (W - b));
        default: r.err = 1;
      endcase
      r.res = RW'(v & mk);
    end
    return r;
  endfunction

  task automatic do_op(input bit m, input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit ci, input bit split, input int gap);
    exp_t x;
    int   cyc;
    x = model(m, c, longint'(a), longint'(b), ci);
    mode = m; cmd = 4'(c); cin = ci; opa = a; opb = b;
    if (!split) begin
      inp_valid = 2'b11;
      tick();
    end else begin
      inp_valid = 2'b01;
      tick();
      for (int i = 0; i < gap; i++) begin
        inp_valid = 2'b00; opa = W'($urandom); opb = W'($urandom); cmd = 4'($urandom);
        check_eq("wait_busy", {busy, res_valid}, 2'b10);
        tick();
      end
      opa = W'($urandom); cmd = 4'($urandom); mode = 1'($urandom); cin = 1'($urandom);
      opb = b; inp_valid = 2'b10;
      tick();
    end
    inp_valid = 2'b00;
    cyc = 1;
    while (!res_valid && cyc < 64) begin
      if (x.lat > 1) check_eq("mul_busy", busy, 1);
      tick();
      cyc++;
    end
    check_eq("latency", cyc, x.lat);
    check_eq("res", res, x.res);
    check_eq("flags", {cout, oflow, g, l, e, err}, {x.cout, x.oflow, x.g, x.l, x.e, x.err});
    $display("[TB] op mode=%0d cmd=%0d a=%0h b=%0h cin=%0d split=%0d res=%0h err=%0b lat=%0d",
             m, c, a, b, ci, split, res, err, cyc);
    tick();
    check_eq("pulse_hold", {res_valid, res}, {1'b0, x.res});
  endtask

  initial begin
    int cyc;
    int pulses;
    #1;
    check_eq("reset_out", {res, oflow, cout, g, l, e, err, res_valid, busy}, '0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_quiet", {res_valid, busy}, 2'b00);
    end

    do_op(1, 0, 8'hFF, 8'h01, 0, 0, 0);
    do_op(1, 9, 8'd3, 8'd4, 0, 0, 0);
    do_op(1, 1, 8'd10, 8'd3, 0, 1, 4);
    do_op(0, 12, 8'h81, 8'h08, 0, 0, 0);
    do_op(0, 12, 8'h81, 8'h01, 0, 0, 0);
    do_op(1, 5, 8'h00, 8'h00, 0, 0, 0);
    do_op(1, 15, 8'h12, 8'h34, 0, 0, 0);

    // Timeout: opb never arrives.
    mode = 0; cmd = 4'd4; opa = 8'h5A; opb = 8'h00; inp_valid = 2'b01;
    tick();
    cyc = 1;
    while (!res_valid && cyc < 64) begin
      check_eq("timeout_busy", busy, 1);
      tick();
      cyc++;
    end
    inp_valid = 2'b00;
    check_eq("timeout_lat", cyc, WAITC + 1);
    check_eq("timeout_res", {res, err}, {16'h0000, 1'b1});
    $display("[TB] op timeout res=%0h err=%0b lat=%0d", res, err, cyc);
    tick();

    // ce low for two cycles mid-multiply stretches latency by two.
    mode = 1; cmd = 4'd9; opa = 8'd5; opb = 8'd6; inp_valid = 2'b11;
    tick();
    inp_valid = 2'b00; ce = 1'b0;
    tick();
    check_eq("ce_hold_valid", res_valid, 0);
    tick();
    check_eq("ce_hold_busy", busy, 1);
    ce = 1'b1;
    cyc = 3;
    while (!res_valid && cyc < 64) begin tick(); cyc++; end
    check_eq("ce_lat", cyc, MLAT + 2);
    check_eq("ce_res", res, 16'd42);
    $display("[TB] op ce-stall mul res=%0d lat=%0d", res, cyc);
    tick();

    // Reset one cycle into a multiply discards it.
    do_op(1, 0, 8'd3, 8'd4, 0, 0, 0);
    mode = 1; cmd = 4'd10; opa = 8'd7; opb = 8'd9; inp_valid = 2'b11;
    tick();
    inp_valid = 2'b00;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_mul", {res, oflow, cout, g, l, e, err, res_valid, busy}, '0);
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid || busy) pulses++;
    end
    check_eq("rst_no_result", pulses, 0);
    $display("[TB] op reset mid-mul discarded");

    for (int n = 0; n < 150; n++) begin
      bit           m;
      int           c;
      logic [W-1:0] a, b;
      bit           sp;
      m = 1'($urandom);
      c = int'($urandom_range(0, 15));
      a = W'($urandom);
      b = W'($urandom);
      if (!m && (c == 12 || c == 13) && $urandom_range(0, 1) == 1) b = W'($urandom_range(0, W - 1));
      sp = two_op(m, c) && ($urandom_range(0, 2) == 0);
      do_op(m, c, a, b, 1'($urandom), sp, int'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
